c_write_buffer: RTL

- Parametrised write-back buffer between the cache's memory port and the block memory.
- Queues evicted dirty blocks in a DEPTH-entry FIFO and drains them to memory in the background.
- Read misses take priority over pending drains; a read miss whose block is still buffered is served directly from the buffer.
- Replaces the direct cache-to-memory write path. The cache stalls only when the buffer is full or a read is outstanding.

---
 rtl/c_wb_pkg.sv | 21 ++
 rtl/c_wb_match.sv | 35 +++
 rtl/c_write_buffer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/c_wb_pkg.sv
// Shared types and width helpers for the c_write_buffer write-back buffer.
package c_wb_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_FWD
  } wb_state_e;

  function automatic int unsigned ba_width(input int unsigned address_size,
                                           input int unsigned block_size);
    return address_size - block_size - 2;
  endfunction

  function automatic int unsigned block_width(input int unsigned block_size,
                                              input int unsigned line_size);
    return (1 << block_size) * line_size;
  endfunction

endpackage

// File: rtl/c_wb_match.sv
// DEPTH-way address compare against valid buffer entries; reports the youngest
// match, where age is measured from the head (oldest) pointer.
module c_wb_match
  import c_wb_pkg::*;
#(
  parameter  int BA    = 28,
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]         valid_i,
  input  logic [DEPTH-1:0][BA-1:0] addr_i,
  input  logic [PW-1:0]            head_i,
  input  logic [BA-1:0]            key_i,
  output logic                     hit_o,
  output logic [PW-1:0]            idx_o
);

  logic [PW-1:0] slot;

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    hit_o = 1'b0;
    idx_o = head_i;
    slot  = head_i;
    // Walk oldest to youngest so the last hit wins.
    for (int j = 0; j < DEPTH; j++) begin
      slot = head_i + PW'(j);
      if (valid_i[slot] && (addr_i[slot] == key_i)) begin
        hit_o = 1'b1;
        idx_o = slot;
      end
    end
  end

endmodule

// File: rtl/c_write_buffer.sv
// Write-back buffer: queues evicted blocks in a FIFO and drains them to memory,
// giving read misses priority. Optional in-place coalescing via WB_COALESCE_EN.
module c_write_buffer
  import c_wb_pkg::*;
#(
  parameter  int BLOCK_SIZE   = 2,
  parameter  int LINE_SIZE    = 32,
  parameter  int ADDRESS_SIZE = 32,
  parameter  int DEPTH        = 4,
  localparam int BA           = ba_width(ADDRESS_SIZE, BLOCK_SIZE),
  localparam int BW           = block_width(BLOCK_SIZE, LINE_SIZE)
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  input  logic          wb_wr_i,
  input  logic [BA-1:0] wb_wr_addr_i,
  input  logic [BW-1:0] wb_wr_data_i,
  output logic          wb_busywait_o,
  input  logic          wb_rd_i,
  input  logic [BA-1:0] wb_rd_addr_i,
  output logic [BW-1:0] wb_rd_data_o,
  output logic          wb_rd_done_o,
  output logic          m_read_o,
  output logic          m_wr_o,
  output logic [BA-1:0] m_address_o,
  output logic [BW-1:0] m_write_data_o,
  input  logic          m_busywait_i,
  input  logic [BW-1:0] m_read_data_i,
  input  logic          m_write_done_i,
  input  logic          m_read_done_i
);

  localparam int            PW   = $clog2(DEPTH);
  localparam logic [PW:0]   FULL = (PW+1)'(DEPTH);

  wb_state_e                state_q, state_d;
  logic [PW-1:0]            head_q, head_d, tail_q, tail_d;
  logic [PW:0]              count_q, count_d;
  logic [DEPTH-1:0]         valid_q, valid_d;
  logic [DEPTH-1:0][BA-1:0] addr_q, addr_d;
  logic [BW-1:0]            data_q [DEPTH];
  logic [BW-1:0]            data_d [DEPTH];
  logic [BA-1:0]            rd_addr_q, rd_addr_d;
  logic [BW-1:0]            rd_data_q, rd_data_d;

  logic          full, push, pop, coalesce, rd_hit;
  logic [PW-1:0] rd_idx, wr_idx;
  wire           unused_busywait = m_busywait_i;

  assign full = (count_q == FULL);
  assign pop  = (state_q == S_WRITE) && m_write_done_i;

  c_wb_match #(.BA(BA), .DEPTH(DEPTH)) u_rd_match (
    .valid_i (valid_q),
    .addr_i  (addr_q),
    .head_i  (head_q),
    .key_i   (wb_rd_addr_i),
    .hit_o   (rd_hit),
    .idx_o   (rd_idx)
  );

`ifdef WB_COALESCE_EN
  logic wr_hit;

  c_wb_match #(.BA(BA), .DEPTH(DEPTH)) u_wr_match (
    .valid_i (valid_q),
    .addr_i  (addr_q),
    .head_i  (head_q),
    .key_i   (wb_wr_addr_i),
    .hit_o   (wr_hit),
    .idx_o   (wr_idx)
  );

  // The head being drained must keep its data stable on the memory bus.
  assign coalesce = wb_wr_i && wr_hit && !((state_q == S_WRITE) && (wr_idx == head_q));
`else
  assign coalesce = 1'b0;
  assign wr_idx   = tail_q;
`endif

  assign push = wb_wr_i && !coalesce && !full;

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (coalesce) data_d[wr_idx] = wb_wr_data_i;
    if (push) begin
      valid_d[tail_q] = 1'b1;
      addr_d[tail_q]  = wb_wr_addr_i;
      data_d[tail_q]  = wb_wr_data_i;
      tail_d          = tail_q + PW'(1);
    end
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PW'(1);
    end
    count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
  end

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    case (state_q)
      S_IDLE: begin
        if (wb_rd_i) begin
          if (rd_hit) begin
            state_d   = S_FWD;
            rd_data_d = data_q[rd_idx];
          end else begin
            state_d   = S_READ;
            rd_addr_d = wb_rd_addr_i;
          end
        end else if (count_q != '0) begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: if (m_write_done_i) state_d = S_IDLE;
      S_READ: begin
        if (m_read_done_i) begin
          rd_data_d = m_read_data_i;
          state_d   = S_FWD;
        end
      end
      S_FWD:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= S_IDLE;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      valid_q   <= '0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
    end
  end

  // NOTE: entry storage has no reset; the valid bits alone decide what is live.
  always_ff @(posedge clk_i) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  assign wb_busywait_o  = full;
  assign wb_rd_done_o   = (state_q == S_FWD);
  assign wb_rd_data_o   = wb_rd_done_o ? rd_data_q : '0;
  assign m_read_o       = (state_q == S_READ);
  assign m_wr_o         = (state_q == S_WRITE);
  assign m_address_o    = m_read_o ? rd_addr_q : (m_wr_o ? addr_q[head_q] : '0);
  assign m_write_data_o = m_wr_o ? data_q[head_q] : '0;

endmodule
